z3_slave_cycle: RTL and testbench

- Zorro III slave-cycle controller that sits directly upstream of the SCSI register access stage.
- Detects a card-addressed bus cycle and claims it (SLAVE_n).
- Opens a region-specific cycle window: scsi_cycle for NCR registers, rom_cycle for boot ROM.
- Drives DTACK_n back to the host from the downstream ready/acknowledge, with a watchdog so a stalled access never hangs the bus.

---
 rtl/z3_slave_cycle_pkg.sv | 20 ++
 rtl/z3_slave_cycle_if.sv | 30 +++
 rtl/z3_slave_cycle_sync.sv | 30 +++
 rtl/z3_slave_cycle.sv | 168 ++++++++++++++++
 tb/tb_z3_slave_cycle.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/z3_slave_cycle_pkg.sv
// rtl/z3_slave_cycle_pkg.sv - shared state, region and default-parameter definitions for the Zorro III slave-cycle controller
package z3_pkg;

    // Bus-cycle sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLAIM   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_TERM    = 3'd3,
        ST_RECOVER = 3'd4
    } z3_state_t;

    // Region latched at claim time
    localparam logic REGION_ROM  = 1'b0;
    localparam logic REGION_SCSI = 1'b1;

    localparam int Z3_TIMEOUT_DEFAULT = 64;
    localparam int Z3_SYNC_DEFAULT    = 2;

endpackage

// File: rtl/z3_slave_cycle_if.sv
// rtl/z3_slave_cycle_if.sv - Zorro III slave-cycle bus signals with host-side and card-side modports
interface z3_slave_cycle_if;

    logic       FCS_n;
    logic       addr_hit;
    logic       addr_scsi;
    logic       DOE;
    logic [3:0] DS_n;
    logic       READ;
    logic       mybus;
    logic       scsi_dtack;
    logic       rom_ready;
    logic       scsi_cycle;
    logic       rom_cycle;
    logic       SLAVE_n;
    logic       DTACK_n;
    logic       BERR_n;
    logic       timeout;

    modport slave (
        input  FCS_n, addr_hit, addr_scsi, DOE, DS_n, READ, mybus, scsi_dtack, rom_ready,
        output scsi_cycle, rom_cycle, SLAVE_n, DTACK_n, BERR_n, timeout
    );

    modport master (
        output FCS_n, addr_hit, addr_scsi, DOE, DS_n, READ, mybus, scsi_dtack, rom_ready,
        input  scsi_cycle, rom_cycle, SLAVE_n, DTACK_n, BERR_n, timeout
    );

endinterface

// File: rtl/z3_slave_cycle_sync.sv
// rtl/z3_slave_cycle_sync.sv - multi-stage synchronizer whose stages preset to 1 on reset
module z3_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    // Shift the asynchronous input one stage deeper each clock; stage 0 is the newest sample
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    // Stage register; presets high so a released strobe is seen after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '1;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/z3_slave_cycle.sv
// rtl/z3_slave_cycle.sv - Zorro III slave-cycle controller; define Z3_BERR_EN to end watchdog timeouts with BERR_n
module z3_slave_cycle
    import z3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = Z3_TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES    = Z3_SYNC_DEFAULT
) (
    input  logic            bclk,
    input  logic            reset,
    z3_slave_cycle_if.slave bus
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic fcs_s;

    z3_state_t     state_q,      state_d;
    logic          region_q,     region_d;
    logic [CW-1:0] counter_q,    counter_d;
    logic          fcs_prev_q,   fcs_prev_d;
    logic          scsi_cycle_q, scsi_cycle_d;
    logic          rom_cycle_q,  rom_cycle_d;
    logic          slave_n_q,    slave_n_d;
    logic          dtack_n_q,    dtack_n_d;
    logic          timeout_q,    timeout_d;
`ifdef Z3_BERR_EN
    logic          berr_n_q,     berr_n_d;
`endif

    logic start_evt;
    logic claim_ok;
    logic ready;
    logic go_idle;

    z3_sync #(.STAGES(SYNC_STAGES)) u_fcs_sync (
        .clk (bclk),
        .rst (reset),
        .d   (bus.FCS_n),
        .q   (fcs_s)
    );

    // Next state and next registered outputs; every output is a flop so the bus sees clean edges
    always_comb begin
        state_d      = state_q;
        region_d     = region_q;
        counter_d    = counter_q;
        fcs_prev_d   = fcs_s;
        scsi_cycle_d = scsi_cycle_q;
        rom_cycle_d  = rom_cycle_q;
        slave_n_d    = slave_n_q;
        dtack_n_d    = dtack_n_q;
        timeout_d    = 1'b0;
`ifdef Z3_BERR_EN
        berr_n_d     = berr_n_q;
`endif
        go_idle      = 1'b0;

        start_evt = fcs_prev_q && !fcs_s;
        claim_ok  = start_evt && bus.addr_hit && !bus.mybus;
        ready     = ((region_q == REGION_SCSI) ? bus.scsi_dtack : bus.rom_ready)
                    && bus.DOE && (bus.DS_n != 4'hF);

        case (state_q)
            // RECOVER is a single idle-output cycle; it may accept a start that lands in it so a
            // one-bclk FCS_n gap between back-to-back cycles is not lost
            ST_IDLE, ST_RECOVER: begin
                state_d = ST_IDLE;
                go_idle = 1'b1;
                if (claim_ok) begin
                    go_idle      = 1'b0;
                    state_d      = ST_CLAIM;
                    region_d     = bus.addr_scsi;
                    slave_n_d    = 1'b0;
                    scsi_cycle_d = bus.addr_scsi;
                    rom_cycle_d  = !bus.addr_scsi;
                end
            end
            ST_CLAIM: begin
                counter_d = '0;
                state_d   = ST_WAIT;
            end
            // Host release beats a same-edge ready so an aborted cycle never sees DTACK_n
            ST_WAIT: begin
                if (fcs_s) begin
                    state_d = ST_RECOVER;
                    go_idle = 1'b1;
                end else if (ready) begin
                    state_d   = ST_TERM;
                    dtack_n_d = 1'b0;
                end else if (counter_q == CNT_LAST) begin
                    state_d   = ST_TERM;
                    timeout_d = 1'b1;
`ifdef Z3_BERR_EN
                    berr_n_d  = 1'b0;
`else
                    dtack_n_d = 1'b0;
`endif
                end else if (counter_q != '1) begin
                    counter_d = counter_q + 1'b1;
                end
            end
            ST_TERM: begin
                if (fcs_s) begin
                    state_d = ST_RECOVER;
                    go_idle = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            scsi_cycle_d = 1'b0;
            rom_cycle_d  = 1'b0;
            slave_n_d    = 1'b1;
            dtack_n_d    = 1'b1;
`ifdef Z3_BERR_EN
            berr_n_d     = 1'b1;
`endif
        end
    end

    // State and output registers with synchronous reset to idle values
    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            region_q     <= REGION_ROM;
            counter_q    <= '0;
            fcs_prev_q   <= 1'b1;
            scsi_cycle_q <= 1'b0;
            rom_cycle_q  <= 1'b0;
            slave_n_q    <= 1'b1;
            dtack_n_q    <= 1'b1;
            timeout_q    <= 1'b0;
`ifdef Z3_BERR_EN
            berr_n_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            counter_q    <= counter_d;
            fcs_prev_q   <= fcs_prev_d;
            scsi_cycle_q <= scsi_cycle_d;
            rom_cycle_q  <= rom_cycle_d;
            slave_n_q    <= slave_n_d;
            dtack_n_q    <= dtack_n_d;
            timeout_q    <= timeout_d;
`ifdef Z3_BERR_EN
            berr_n_q     <= berr_n_d;
`endif
        end
    end

    assign bus.scsi_cycle = scsi_cycle_q;
    assign bus.rom_cycle  = rom_cycle_q;
    assign bus.SLAVE_n    = slave_n_q;
    assign bus.DTACK_n    = dtack_n_q;
    assign bus.timeout    = timeout_q;
`ifdef Z3_BERR_EN
    assign bus.BERR_n     = berr_n_q;
`else
    assign bus.BERR_n     = 1'b1;
`endif

endmodule

// File: tb/tb_z3_slave_cycle.sv
// tb/tb_z3_slave_cycle.sv - scoreboard bench for the Zorro III slave-cycle controller
module tb_z3_slave_cycle;

    localparam int T  = 64;
    localparam int SS = 2;
`ifdef Z3_BERR_EN
    localparam int TO_KIND = 2;
`else
    localparam int TO_KIND = 1;
`endif

    typedef struct {
        int claim_cyc;
        int region;
        int kind;
        int term_cyc;
        int to_flag;
        int release_cyc;
    } exp_t;

    logic bclk = 1'b0;
    logic reset = 1'b1;
    z3_slave_cycle_if bus();

    z3_slave_cycle #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(SS)) dut (
        .bclk  (bclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 bclk = ~bclk;

    int cyc = 0;
    always @(posedge bclk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   mon_en = 1'b0;

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: cycle numbers follow from the rules, counted from the cycle FCS_n is driven low
    function automatic exp_t model(int n, int region, int d, int len, int gap, bit doe, logic [3:0] ds);
        exp_t e;
        int ws, h, tr, tcyc, kind, to;
        ws   = n + SS + 2;
        h    = n + len;
        tcyc = ws + T;
        kind = TO_KIND;
        to   = 1;
        if (d <= len + gap && doe && ds != 4'hF) begin
            tr = (n + d + 1 > ws + 1) ? n + d + 1 : ws + 1;
            if (tr <= ws + T) begin
                tcyc = tr;
                kind = 1;
                to   = 0;
            end
        end
        if (tcyc > h + SS) begin
            kind = 0;
            to   = 0;
            tcyc = -1;
        end
        e.claim_cyc   = n + SS + 1;
        e.region      = region;
        e.kind        = kind;
        e.term_cyc    = tcyc;
        e.to_flag     = to;
        e.release_cyc = h + SS + 1;
        return e;
    endfunction

    // Monitor: builds one observed record per claimed cycle and scores it against the queue
    int in_cyc = 0;
    int o_claim, o_region, o_dt, o_be, o_to_cyc, o_to_cnt, o_err;
    int stray = 0;
    always @(negedge bclk) begin
        if (mon_en) begin
            if (in_cyc == 0) begin
                if (bus.SLAVE_n === 1'b0) begin
                    in_cyc   = 1;
                    o_claim  = cyc;
                    o_region = (bus.scsi_cycle === 1'b1) ? 1 : 0;
                    o_dt = -1; o_be = -1; o_to_cyc = -1; o_to_cnt = 0; o_err = 0;
                end else if (bus.scsi_cycle !== 1'b0 || bus.rom_cycle !== 1'b0 || bus.DTACK_n !== 1'b1
                             || bus.BERR_n !== 1'b1 || bus.timeout !== 1'b0) begin
                    stray++;
                end
            end
            if (in_cyc != 0) begin
                if (bus.SLAVE_n === 1'b1) begin
                    in_cyc = 0;
                    if (bus.scsi_cycle !== 1'b0 || bus.rom_cycle !== 1'b0 || bus.DTACK_n !== 1'b1
                        || bus.BERR_n !== 1'b1 || bus.timeout !== 1'b0) stray++;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_claim at cycle %0d: claim seen at %0d, required none", cyc, o_claim);
                    end else begin
                        exp_t e;
                        int   ok, ot;
                        e  = q.pop_front();
                        ok = (o_dt >= 0 && o_be >= 0) ? 3 : (o_dt >= 0) ? 1 : (o_be >= 0) ? 2 : 0;
                        ot = (o_dt >= 0) ? o_dt : o_be;
                        check("claim_cycle", o_claim, e.claim_cyc);
                        check("region", o_region, e.region);
                        check("term_kind", ok, e.kind);
                        check("term_cycle", ot, e.term_cyc);
                        check("timeout_cycle", o_to_cyc, e.to_flag ? e.term_cyc : -1);
                        check("timeout_pulses", o_to_cnt, e.to_flag);
                        check("release_cycle", cyc, e.release_cyc);
                        check("window_hold", o_err, 0);
                    end
                end else begin
                    if (bus.scsi_cycle !== (o_region == 1) || bus.rom_cycle !== (o_region == 0)) o_err++;
                    if (bus.DTACK_n === 1'b0 && o_dt < 0) o_dt = cyc;
                    else if (bus.DTACK_n !== 1'b0 && o_dt >= 0) o_err++;
                    if (bus.BERR_n === 1'b0 && o_be < 0) o_be = cyc;
                    else if (bus.BERR_n !== 1'b0 && o_be >= 0) o_err++;
                    if (bus.timeout === 1'b1) begin
                        o_to_cnt++;
                        if (o_to_cyc < 0) o_to_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge bclk);
        #1;
    endtask

    task automatic check_idle(string tag);
        check({tag, "_scsi_cycle"}, bus.scsi_cycle, 0);
        check({tag, "_rom_cycle"}, bus.rom_cycle, 0);
        check({tag, "_SLAVE_n"}, bus.SLAVE_n, 1);
        check({tag, "_DTACK_n"}, bus.DTACK_n, 1);
        check({tag, "_BERR_n"}, bus.BERR_n, 1);
        check({tag, "_timeout"}, bus.timeout, 0);
    endtask

    // One host bus cycle: FCS_n low for len cycles, then high for gap cycles; ready rises at step d
    task automatic run_txn(bit hit, bit mb, bit reg_scsi, bit rd, int d, int len, int gap,
                           bit doe, logic [3:0] ds, bit mb_mid, bit wrong_rdy);
        int n;
        n = cyc;
        bus.FCS_n     = 1'b0;
        bus.addr_hit  = hit;
        bus.addr_scsi = reg_scsi;
        bus.READ      = rd;
        bus.mybus     = mb;
        bus.DOE       = doe;
        bus.DS_n      = ds;
        if (wrong_rdy) begin
            if (reg_scsi) bus.rom_ready = 1'b1;
            else          bus.scsi_dtack = 1'b1;
        end
        if (hit && !mb) q.push_back(model(n, reg_scsi ? 1 : 0, d, len, gap, doe, ds));
        for (int k = 1; k <= len + gap; k++) begin
            next_cyc();
            if (k == d) begin
                if (reg_scsi) bus.scsi_dtack = 1'b1;
                else          bus.rom_ready = 1'b1;
            end
            if (k == 5 && k < len && mb_mid) bus.mybus = 1'b1;
            if (k == len) begin
                bus.FCS_n = 1'b1;
                bus.mybus = 1'b0;
            end
        end
        bus.scsi_dtack = 1'b0;
        bus.rom_ready  = 1'b0;
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL run_time_limit: cycle %0d, required completion", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int   n, len, d;
        exp_t e;
        bus.FCS_n = 1'b1; bus.addr_hit = 1'b0; bus.addr_scsi = 1'b0; bus.DOE = 1'b0;
        bus.DS_n = 4'hF; bus.READ = 1'b1; bus.mybus = 1'b0; bus.scsi_dtack = 1'b0; bus.rom_ready = 1'b0;
        reset = 1'b1;
        repeat (3) next_cyc();
        check_idle("reset");
        reset = 1'b0;
        next_cyc();
        mon_en = 1'b1;

        run_txn(1, 0, 1, 1, 6, 12, 2, 1, 4'h0, 0, 0);     // SCSI read
        run_txn(0, 0, 0, 1, 3, 20, 2, 1, 4'h0, 0, 0);     // address miss
        run_txn(1, 1, 1, 1, 3, 20, 2, 1, 4'h0, 0, 0);     // card is master
        run_txn(1, 0, 0, 1, 999, 75, 2, 1, 4'h0, 0, 0);   // ROM watchdog
        run_txn(1, 0, 0, 1, 6, 75, 2, 0, 4'h0, 0, 0);     // ready without DOE times out
        run_txn(1, 0, 1, 1, 12, 10, 3, 1, 4'h0, 0, 0);    // ready on the same edge as host release

        // Reset while DTACK_n is asserted
        n = cyc;
        bus.FCS_n = 1'b0; bus.addr_hit = 1'b1; bus.addr_scsi = 1'b1; bus.DOE = 1'b1; bus.DS_n = 4'h0;
        e.claim_cyc = n + SS + 1; e.region = 1; e.kind = 1; e.term_cyc = n + SS + 3;
        e.to_flag = 0; e.release_cyc = n + 9;
        q.push_back(e);
        for (int k = 1; k <= 8; k++) begin
            next_cyc();
            if (k == 1) bus.scsi_dtack = 1'b1;
        end
        check("pre_reset_DTACK_n", bus.DTACK_n, 0);
        reset = 1'b1; bus.FCS_n = 1'b1; bus.scsi_dtack = 1'b0;
        next_cyc();
        check_idle("mid_reset");
        reset = 1'b0;
        repeat (2) next_cyc();
        run_txn(1, 0, 1, 1, 4, 10, 2, 1, 4'h0, 0, 0);     // claims normally after reset

        run_txn(1, 0, 1, 0, 5, 8, 1, 1, 4'h0, 0, 0);      // back-to-back writes
        run_txn(1, 0, 1, 0, 5, 8, 1, 1, 4'h0, 0, 0);
        run_txn(1, 0, 1, 1, 20, 30, 2, 1, 4'h3, 1, 1);    // mybus rises mid-cycle, wrong source active

        for (int i = 0; i < 30; i++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(66, 85)) : int'($urandom_range(4, 25));
            d   = ($urandom_range(0, 4) == 0) ? 999 : int'($urandom_range(1, len + 3));
            run_txn($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), d, len, $urandom_range(1, 3), $urandom_range(0, 7) != 0,
                    ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        repeat (10) next_cyc();
        check("queue_drained", q.size(), 0);
        check("stray_outputs", stray, 0);
        check("cycle_closed", in_cyc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
